// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   tx_state_t      : transmitter FSM states
//   PAR_NONE/EVEN/ODD : parity mode encodings for the PARITY parameter
//   clks_per_bit()  : clk cycles per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. dout always shows the oldest entry
// while the FIFO is non-empty; a pop simply advances past it.
// Ports:
//   clk, rst : clock and asynchronous active-high reset (flushes the FIFO)
//   push     : write din at this edge (ignored while full)
//   pop      : discard the head entry at this edge (ignored while empty)
//   din/dout : write data / head-of-queue data
//   full, empty, count : occupancy status, count ranges 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; resetting the pointers and count is
    // enough to flush it, and leaving it out keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap at DEPTH by themselves.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: bytes queue in a FIFO and are sent LSB first as
// start / 8 data / optional parity / STOP_BITS stop bits. Frames go out
// back-to-back while bytes are queued.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   tx_data    : byte to queue, written when tx_valid && tx_ready
//   tx_valid   : tx_data is valid
//   tx_ready   : FIFO has room (registered status, no path from tx_valid)
//   tx         : registered serial line, idles high
//   busy       : a frame is in flight or bytes are queued
//   fifo_count : number of queued bytes
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int             CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int             CW        = $clog2(CPB + 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CPB - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t     state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          pop;
    logic          bit_done;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign bit_done = (baud_cnt == BIT_LAST);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        pop           = 1'b0;

        unique case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next    = DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_done) begin
                    state_next    = STOP;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                end
            end
            STOP: begin
                // bit_idx counts stop bits here so each one is a full bit time.
                if (bit_done) begin
                    baud_cnt_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_next = '0;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = fifo_dout;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so the line changes on the same
        // edge as the state, keeping bit boundaries exactly CPB cycles apart.
        unique case (state_next)
            START:            tx_next = 1'b0;
            DATA:             tx_next = shift_next[bit_idx_next];
            uart_pkg::PARITY: tx_next = (^shift_next) ^ (PARITY == PAR_ODD);
            default:          tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Four transmitters share clk/rst:
//   d0: 8 clks/bit, no parity, 1 stop     d1: 8 clks/bit, even parity, 1 stop
//   d2: 8 clks/bit, odd parity, 2 stops   d3: default parameters (5208 clks/bit)
// A frame-level model (byte queue + frame bit vector + elapsed time) predicts
// tx, busy, fifo_count and tx_ready after every edge; directed tests add
// hand-computed frame images, edge times and lengths.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int ND    = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din   [ND];
    logic       valid [ND];
    logic       ready [ND];
    logic       txo   [ND];
    logic       busyo [ND];
    logic [4:0] cnt   [ND];

    always #10 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(6_250_000), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(din[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .tx(txo[0]), .busy(busyo[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(6_250_000), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(din[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .tx(txo[1]), .busy(busyo[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(6_250_000), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(din[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .tx(txo[2]), .busy(busyo[2]), .fifo_count(cnt[2]));
    uart_tx_fifo dut3 (
        .clk(clk), .rst(rst), .tx_data(din[3]), .tx_valid(valid[3]), .tx_ready(ready[3]),
        .tx(txo[3]), .busy(busyo[3]), .fifo_count(cnt[3]));

    // ---------------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int i);
        return (i == 3) ? 5208 : 8;
    endfunction

    function automatic int par_of(input int i);
        case (i)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stb_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int nbits_of(input int i);
        return 9 + ((par_of(i) != 0) ? 1 : 0) + stb_of(i);
    endfunction

    // Frame image, bit 0 first on the line; unused upper bits stay high (stop/idle).
    function automatic logic [11:0] make_frame(input logic [7:0] b, input int par);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par != 0) f[9] = (^b) ^ (par == 2);
        return f;
    endfunction

    // ------------------------------------------------------------------ model
    logic [7:0]  mq [ND][$];
    bit          m_act   [ND];
    longint      m_start [ND];
    logic [11:0] m_frame [ND];
    logic        exp_tx   [ND];
    logic        exp_busy [ND];
    int          exp_cnt  [ND];
    longint      edge_n = 0;
    int          m_pre;
    bit          m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                mq[i].delete();
                m_act[i]    = 1'b0;
                exp_tx[i]   = 1'b1;
                exp_busy[i] = 1'b0;
                exp_cnt[i]  = 0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < ND; i++) begin
                m_pre = mq[i].size();
                m_pop = 1'b0;
                if (!m_act[i]) begin
                    m_pop = (m_pre != 0);
                end else if (edge_n - m_start[i] == longint'(nbits_of(i) * cpb_of(i))) begin
                    m_pop = (m_pre != 0);
                    if (m_pre == 0) m_act[i] = 1'b0;
                end
                if (m_pop) begin
                    m_frame[i] = make_frame(mq[i].pop_front(), par_of(i));
                    m_act[i]   = 1'b1;
                    m_start[i] = edge_n;
                end
                if (valid[i] && m_pre < DEPTH) mq[i].push_back(din[i]);
                exp_tx[i]   = m_act[i] ? m_frame[i][int'((edge_n - m_start[i]) / cpb_of(i))] : 1'b1;
                exp_busy[i] = m_act[i] || (mq[i].size() != 0);
                exp_cnt[i]  = mq[i].size();
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < ND; i++) begin
                check($sformatf("tx[%0d]", i), txo[i], exp_tx[i]);
                check($sformatf("busy[%0d]", i), busyo[i], exp_busy[i]);
                check($sformatf("fifo_count[%0d]", i), cnt[i], exp_cnt[i]);
                check($sformatf("tx_ready[%0d]", i), ready[i], (exp_cnt[i] < DEPTH));
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    // Called at a negedge; returns at the next negedge with edge_n = push edge.
    task automatic push_one(input int d, input logic [7:0] b, output longint pe);
        din[d]   = b;
        valid[d] = 1'b1;
        @(negedge clk);
        valid[d] = 1'b0;
        pe       = edge_n;
    endtask

    // Waits for a start bit, then samples nbits mid-bit; t0 is the start edge.
    task automatic get_frame(input int d, input int nbits, output logic [11:0] f, output longint t0);
        int g;
        g  = 0;
        f  = '1;
        t0 = edge_n;
        while (txo[d] !== 1'b0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("start_seen[%0d]", d), txo[d], 1'b0);
        if (txo[d] !== 1'b0) return;
        t0 = edge_n;
        repeat (cpb_of(d) / 2) @(negedge clk);
        f[0] = txo[d];
        for (int j = 1; j < nbits; j++) begin
            repeat (cpb_of(d)) @(negedge clk);
            f[j] = txo[d];
        end
    endtask

    task automatic wait_idle(input int d, input int limit);
        int g;
        g = 0;
        while (busyo[d] !== 1'b0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("idle_reached[%0d]", d), busyo[d], 1'b0);
    endtask

    task automatic send_and_check(input int d, input logic [7:0] b, input logic [11:0] exp_f,
                                  input int exp_len);
        longint      pe, t0;
        logic [11:0] f;
        push_one(d, b, pe);
        get_frame(d, nbits_of(d), f, t0);
        check($sformatf("frame_image[%0d]", d), f, exp_f);
        check($sformatf("pop_latency[%0d]", d), t0 - pe, 1);
        wait_idle(d, 200);
        check($sformatf("frame_len[%0d]", d), edge_n - t0, exp_len);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] f;
        longint      pe, p, s0, t0;
        int          k, g, max_cnt;
        logic        prev;
        bit          saw_full;

        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            valid[i] = 1'b0;
            din[i]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        check("rst_tx", txo[0], 1'b1);
        check("rst_busy", busyo[0], 1'b0);
        check("rst_count", cnt[0], 0);
        check("rst_ready", ready[0], 1'b1);

        // 1. Default rate, 0x55: alternating line, transitions every 5208 cycles.
        push_one(3, 8'h55, pe);
        p    = pe + 1;
        prev = txo[3];
        k    = 0;
        g    = 0;
        while (k < 10 && g < 60000) begin
            @(negedge clk);
            g++;
            if (txo[3] !== prev) begin
                check("t1_edge_time", edge_n - p, k * 5208);
                prev = txo[3];
                k++;
            end
        end
        check("t1_transitions", k, 10);
        wait_idle(3, 6000);
        check("t1_frame_end", edge_n - p, 10 * 5208);

        // 2/6. 20 bytes with valid held: FIFO fills, frames contiguous, order kept.
        saw_full = 1'b0;
        max_cnt  = 0;
        fork
            begin
                bit acc;
                for (int b = 0; b < 20; b++) begin
                    din[0]   = 8'(b);
                    valid[0] = 1'b1;
                    g = 0;
                    do begin
                        acc = ready[0];
                        if (cnt[0] == 5'd16 && ready[0] == 1'b0) saw_full = 1'b1;
                        @(negedge clk);
                        if (int'(cnt[0]) > max_cnt) max_cnt = int'(cnt[0]);
                        g++;
                    end while (!acc && g < 2000);
                end
                valid[0] = 1'b0;
            end
            begin
                logic [11:0] rf;
                longint      rt;
                for (int b = 0; b < 20; b++) begin
                    get_frame(0, 10, rf, rt);
                    if (b == 0) s0 = rt;
                    check("t2_byte", rf[8:1], b);
                    check("t2_start_stop", {rf[9], rf[0]}, 2'b10);
                end
            end
        join
        check("t2_full_seen", saw_full, 1'b1);
        check("t6_max_count", max_cnt, 16);
        wait_idle(0, 200);
        check("t2_back_to_back_span", edge_n - s0, 20 * 80);

        // 3. Parity modes and two stop bits.
        fork
            send_and_check(1, 8'h07, 12'hE0E, 11 * 8);
            send_and_check(2, 8'h00, 12'hE00, 12 * 8);
        join

        // 4. Reset during data bit 3 of the second of three queued bytes.
        din[0]   = 8'h11;
        valid[0] = 1'b1;
        @(negedge clk);
        pe = edge_n;
        din[0] = 8'h22;
        @(negedge clk);
        din[0] = 8'h33;
        @(negedge clk);
        valid[0] = 1'b0;
        p = pe + 1 + 80 + 4 * 8 + 4;
        g = 0;
        while (edge_n < p && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("t4_reached_bit3", edge_n, p);
        check("t4_pre_tx", txo[0], 1'b0);
        check("t4_pre_count", cnt[0], 1);
        #3 rst = 1'b1;
        #1;
        check("t4_rst_tx", txo[0], 1'b1);
        check("t4_rst_count", cnt[0], 0);
        check("t4_rst_busy", busyo[0], 1'b0);
        check("t4_rst_ready", ready[0], 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_and_check(0, 8'hA3, 12'hF46, 10 * 8);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered RS232/UART transmitter. It is the counterpart of the serial receiver in design_top and drives a serial line into any 8N1-compatible receiver. Bytes enter through a valid/ready handshake and queue in a FIFO. They are then serialized LSB-first with start, optional parity and stop bits at a fixed baud rate derived from clk. Frames go out back-to-back, with no idle gap between them, while the FIFO is non-empty.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz (20 ns period).
- BAUD, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, giving 5208.
- FIFO_DEPTH, 16, byte entries. Must be a power of 2 and at least 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  in  1  master clock
- rst  in  1  reset. Asynchronous, active-high.
- tx_data  in  8  byte to queue
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  FIFO can accept a byte. Equals !full; no combinational path from tx_valid.
- tx  out  1  serial output, registered. Idle level is high.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued bytes

Behaviour:
- Reset values: tx=1, busy=0, fifo_count=0, tx_ready=1, FSM in IDLE, FIFO flushed.
- An asserted rst mid-frame forces tx high immediately and discards the partial frame and all queued bytes.
- Push: a byte is written on any clk edge where tx_valid && tx_ready. If valid is high while not ready, nothing is written and tx_data is held by the source.
- Pop: occurs in the cycle the FSM leaves IDLE or STOP toward START.
- A simultaneous push and pop leaves fifo_count unchanged.
- When the FIFO is full, a pop frees a slot but tx_ready stays low for that cycle; it rises on the following cycle.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit index of 0..7 selects the bit.
  - PARITY (only when PARITY!=0): even mode sends the XOR of the data bits; odd mode sends its inverse. Held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, go to START with a pop if the FIFO is non-empty, else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change, so every bit lasts exactly CLKS_PER_BIT cycles.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM idle is popped at edge N+1; tx falls after edge N+1.
- Frame length: (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. full = (count==FIFO_DEPTH); empty = (count==0).

Decomposition:
- uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the function clks_per_bit(clk_freq, baud).
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). It has the same clk and rst semantics as the parent.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
1. Defaults, push 0x55 once -> tx low 5208 cycles, then 1,0,1,0,1,0,1,0 at 5208 cycles each, then high. busy drops at the end of the 10*5208-cycle frame.
2. Hold tx_valid high for 20 bytes 0x00..0x13 -> tx_ready goes low once fifo_count reaches 16. All 20 frames are contiguous with no idle cycle between a stop bit and the next start. Decoded bytes are in order.
3. PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x00 -> parity bit 1. Frame is 11*5208 cycles. STOP_BITS=2 adds one more bit time of high.
4. Assert rst during data bit 3 of the second of three queued bytes -> tx is 1 within the same cycle, fifo_count=0, busy=0. After release, a newly pushed 0xA3 transmits correctly.
5. Loop tx into design_top rx and push 0xC4 -> received pulses once, rx_byte=0xC4, recv_error=0.
6. Hold tx_valid=1 with the FIFO full and verify data stays stable -> no byte is lost or duplicated, and the count never exceeds 16.
